// File: rtl/irq_prio_ctrl.sv
// Parametrised 68k interrupt controller: edge-latched sources, fixed priority encode to nIPL.
// Optional IRQ_MASK_EN adds a writable per-source enable mask (default build: mask fixed all ones).
module irq_prio_ctrl #(
   parameter int unsigned NUM_IRQ = 3,
   parameter int unsigned ID_W    = 3
) (
   input  logic               CLK,
   input  logic               nRESET,
   input  logic [NUM_IRQ-1:0] IRQ_SRC,
   input  logic               WR_ACK,
   input  logic [NUM_IRQ-1:0] ACK_BITS,
   input  logic               WR_MASK,
   input  logic [NUM_IRQ-1:0] MASK_BITS,
   output logic [NUM_IRQ-1:0] PENDING,
   output logic [2:0]         nIPL,
   output logic [ID_W-1:0]    IRQ_ID
);

   localparam int unsigned LVL_W = 3;

   if (NUM_IRQ < 1 || NUM_IRQ > 7 || (1 << ID_W) <= NUM_IRQ) begin : g_bad_param
      $error("irq_prio_ctrl: NUM_IRQ must be 1..7 and 2**ID_W > NUM_IRQ");
   end

   logic [NUM_IRQ-1:0] src_d;
   logic [NUM_IRQ-1:0] rise;
   logic [NUM_IRQ-1:0] ack_clr;
   logic [NUM_IRQ-1:0] mask;
   logic [NUM_IRQ-1:0] eff;
   logic [LVL_W-1:0]   win_lvl;
   logic [ID_W-1:0]    win_idx;

   assign rise    = IRQ_SRC & ~src_d;
   assign ack_clr = {NUM_IRQ{WR_ACK}} & ACK_BITS;
   assign eff     = PENDING & mask;

   // Edge detect and pending latches; a new rise beats a same-cycle ack.
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         src_d   <= '0;
         PENDING <= '0;
      end else begin
         src_d   <= IRQ_SRC;
         PENDING <= rise | (PENDING & ~ack_clr);
      end
   end

`ifdef IRQ_MASK_EN
   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         mask <= '1;
      end else if (WR_MASK) begin
         mask <= MASK_BITS;
      end
   end
`else
   logic unused_mask_inputs;
   assign mask               = '1;
   assign unused_mask_inputs = ^{WR_MASK, MASK_BITS};
`endif

   // Lowest enabled index wins; scanning downward lets the lowest overwrite the rest.
   always_comb begin
      win_lvl = '0;
      win_idx = ID_W'(NUM_IRQ);
      for (int i = int'(NUM_IRQ) - 1; i >= 0; i--) begin
         if (eff[i]) begin
            win_lvl = LVL_W'(int'(NUM_IRQ) - i);
            win_idx = ID_W'(i);
         end
      end
   end

   always_ff @(posedge CLK or negedge nRESET) begin
      if (!nRESET) begin
         nIPL   <= 3'b111;
         IRQ_ID <= ID_W'(NUM_IRQ);
      end else begin
         nIPL   <= ~win_lvl;
         IRQ_ID <= win_idx;
      end
   end

endmodule

// File: tb/tb_irq_prio_ctrl.sv
// Randomized and directed bench for irq_prio_ctrl against a behavioural priority model.
module tb_irq_prio_ctrl;

   localparam int unsigned NUM  = 3;
   localparam int unsigned ID_W = 3;

   logic           clk = 1'b0;
   logic           rst_n;
   logic [NUM-1:0] irq_src, ack_bits, mask_bits, pending;
   logic           wr_ack, wr_mask;
   logic [2:0]     nipl;
   logic [ID_W-1:0] irq_id;

   logic [6:0] src7, ack7, pend7;
   logic       wr_ack7;
   logic [2:0] nipl7;
   logic [2:0] id7;

   int n_checks = 0;
   int n_pass   = 0;

   // Reference model state
   bit m_pend [NUM];
   bit m_prev [NUM];
   bit m_mask [NUM];

   always #5 clk = ~clk;

   irq_prio_ctrl #(.NUM_IRQ(NUM), .ID_W(ID_W)) u_dut (
      .CLK(clk), .nRESET(rst_n), .IRQ_SRC(irq_src), .WR_ACK(wr_ack), .ACK_BITS(ack_bits),
      .WR_MASK(wr_mask), .MASK_BITS(mask_bits), .PENDING(pending), .nIPL(nipl), .IRQ_ID(irq_id)
   );

   irq_prio_ctrl #(.NUM_IRQ(7), .ID_W(3)) u_dut7 (
      .CLK(clk), .nRESET(rst_n), .IRQ_SRC(src7), .WR_ACK(wr_ack7), .ACK_BITS(ack7),
      .WR_MASK(1'b0), .MASK_BITS(7'h7f), .PENDING(pend7), .nIPL(nipl7), .IRQ_ID(id7)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
   endtask

   function automatic void model_reset();
      for (int i = 0; i < NUM; i++) begin
         m_pend[i] = 1'b0;
         m_prev[i] = 1'b0;
         m_mask[i] = 1'b1;
      end
   endfunction

   function automatic logic [NUM-1:0] model_pend_vec();
      logic [NUM-1:0] v;
      for (int i = 0; i < NUM; i++) v[i] = m_pend[i];
      return v;
   endfunction

   // One clock: drive inputs, advance past the edge, advance the model, compare.
   task automatic step(input logic [NUM-1:0] src, input logic wa, input logic [NUM-1:0] ab,
                       input logic wm, input logic [NUM-1:0] mb);
      int exp_id;
      int exp_nipl;
      irq_src = src; wr_ack = wa; ack_bits = ab; wr_mask = wm; mask_bits = mb;
      @(posedge clk); #1;
      // Outputs at this edge reflect pending/mask as they stood before it.
      exp_id = NUM;
      for (int i = NUM - 1; i >= 0; i--) if (m_pend[i] && m_mask[i]) exp_id = i;
      exp_nipl = 7 - (NUM - exp_id);
      for (int i = 0; i < NUM; i++) begin
         m_pend[i] = (src[i] && !m_prev[i]) || (m_pend[i] && !(wa && ab[i]));
         m_prev[i] = src[i];
      end
`ifdef IRQ_MASK_EN
      if (wm) for (int i = 0; i < NUM; i++) m_mask[i] = mb[i];
`endif
      check("pending", 32'(pending), 32'(model_pend_vec()));
      check("nipl",    32'(nipl),    32'(exp_nipl));
      check("irq_id",  32'(irq_id),  32'(exp_id));
   endtask

   task automatic idle(input logic [NUM-1:0] src);
      step(src, 1'b0, '0, 1'b0, '1);
   endtask

   initial begin
      rst_n = 1'b0;
      irq_src = '0; wr_ack = 1'b0; ack_bits = '0; wr_mask = 1'b0; mask_bits = '1;
      src7 = '0; wr_ack7 = 1'b0; ack7 = '0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check("rst_pending", 32'(pending), 32'(0));
      check("rst_nipl",    32'(nipl),    32'(3'b111));
      check("rst_id",      32'(irq_id),  32'(NUM));
      rst_n = 1'b1;

      // Priority between ch1 and ch2, then ack each in turn
      idle(3'b110);
      check("t1_pend", 32'(pending), 32'(3'b110));
      idle(3'b110);
      check("t1_nipl_ch1", 32'(nipl), 32'(3'b101));
      step(3'b110, 1'b1, 3'b010, 1'b0, '1);
      idle(3'b110);
      check("t1_nipl_ch2", 32'(nipl), 32'(3'b110));
      step(3'b110, 1'b1, 3'b100, 1'b0, '1);
      idle(3'b000);
      check("t1_nipl_none", 32'(nipl), 32'(3'b111));

      // Source held high through reset release
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_pending", 32'(pending), 32'(0));
      check("mid_rst_nipl",    32'(nipl),    32'(3'b111));
      check("mid_rst_id",      32'(irq_id),  32'(NUM));
      model_reset();
      irq_src = 3'b001;
      @(negedge clk);
      rst_n = 1'b1;
      idle(3'b001);
      check("t2_pend", 32'(pending), 32'(3'b001));
      idle(3'b001);
      check("t2_nipl", 32'(nipl), 32'(3'b100));
      step(3'b000, 1'b1, 3'b001, 1'b0, '1);

      // Ack racing a new ch2 rise
      idle(3'b100);
      idle(3'b000);
      idle(3'b000);
      step(3'b100, 1'b1, 3'b100, 1'b0, '1);
      check("t3_pend_kept", 32'(pending[2]), 32'(1));
      idle(3'b000);
      check("t3_nipl", 32'(nipl), 32'(3'b110));
      step(3'b000, 1'b1, 3'b100, 1'b0, '1);

      // Level-held source acked once, then re-pulsed
      for (int c = 0; c < 20; c++) step(3'b010, c == 5, 3'b010, 1'b0, '1);
      check("t4_pend_clear", 32'(pending[1]), 32'(0));
      idle(3'b000);
      idle(3'b010);
      check("t4_repulse", 32'(pending[1]), 32'(1));
      step(3'b000, 1'b1, 3'b010, 1'b0, '1);
      idle(3'b000);

      // Masking a pending source, then unmasking
      step(3'b000, 1'b0, '0, 1'b1, 3'b011);
      idle(3'b100);
      idle(3'b000);
      step(3'b000, 1'b0, '0, 1'b1, 3'b111);
      idle(3'b000);
      check("t5_unmasked", 32'(nipl), 32'(3'b110));
      step(3'b000, 1'b1, 3'b100, 1'b0, '1);

      // Random traffic
      for (int c = 0; c < 400; c++) begin
         step(NUM'($urandom), ($urandom % 4) == 0, NUM'($urandom),
              ($urandom % 8) == 0, NUM'($urandom));
      end
      step('0, 1'b1, '1, 1'b1, '1);
      idle('0);
      idle('0);

      // Seven-source sweep on the wide instance
      for (int i = 0; i < 7; i++) begin
         src7 = 7'(1) << i;
         @(posedge clk); #1;
         src7 = '0;
         @(posedge clk); #1;
         check($sformatf("sweep_nipl_%0d", i), 32'(nipl7), 32'(i));
         check($sformatf("sweep_id_%0d", i),   32'(id7),   32'(i));
         wr_ack7 = 1'b1; ack7 = '1;
         @(posedge clk); #1;
         wr_ack7 = 1'b0; ack7 = '0;
      end
      src7 = 7'h7f;
      @(posedge clk); #1;
      check("all7_pend", 32'(pend7), 32'(7'h7f));
      @(posedge clk); #1;
      check("all7_nipl", 32'(nipl7), 32'(3'b000));
      check("all7_id",   32'(id7),   32'(0));

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
